// File: rtl/result_collector_if.sv
// Result collector bus: pipeline tap, consumer valid/ack port, status.
interface result_collector_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
);
  logic             input_valid;
  logic [WIDTH-1:0] result;
  logic             result_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ack;
  logic [CNT_W-1:0] outstanding;
  logic             overflow_err;
  logic             unexpected_err;
  logic             timeout_err;
  logic             clear_err;

  modport master (
    input  input_valid, result, result_ready,
    input  out_ack, clear_err,
    output out_data, out_valid, outstanding,
    output overflow_err, unexpected_err, timeout_err
  );

  modport slave (
    output input_valid, result, result_ready,
    output out_ack, clear_err,
    input  out_data, out_valid, outstanding,
    input  overflow_err, unexpected_err, timeout_err
  );
endinterface

// File: rtl/result_collector.sv
// Buffers pipeline results in a FIFO and tracks in-flight work.
// Optional watchdog enabled by defining RESULT_TIMEOUT_EN.
module result_collector #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  result_collector_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             iv_q;
  logic             issue_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_hit;
  logic             unexp;
  logic             to_set;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             drop;

  logic ovf_q;
  logic unx_q;
  logic to_q;

  // issue_q is the registered 0->1 edge of the held issue strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iv_q    <= 1'b0;
      issue_q <= 1'b0;
    end else begin
      iv_q    <= bus.input_valid;
      issue_q <= bus.input_valid & ~iv_q;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    sat_hit = 1'b0;
    if (issue_q && !bus.result_ready) begin
      if (cnt == CMAX) sat_hit = 1'b1;
      else cnt_nxt = cnt + CNT_W'(1);
    end else if (!issue_q && bus.result_ready) begin
      if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
    end
  end

  assign unexp = bus.result_ready && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = !empty && bus.out_ack;
  assign do_push = bus.result_ready && (!full || pop);
  assign drop    = bus.result_ready && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
    end
  end

  // Push into a full FIFO reuses the slot the head is leaving
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= bus.result;
  end

`ifdef RESULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd;
  logic          wd_clr;

  assign wd_clr = bus.result_ready || (cnt == '0);
  assign to_set = !wd_clr && (wd == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     wd <= '0;
    else if (wd_clr)               wd <= '0;
    else if (wd != TW'(TIMEOUT))   wd <= wd + TW'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign to_set = 1'b0;
`endif

  // A new error event wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unx_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.clear_err) | sat_hit | drop;
      unx_q <= (unx_q & ~bus.clear_err) | unexp;
      to_q  <= (to_q  & ~bus.clear_err) | to_set;
    end
  end

  assign bus.out_valid      = !empty;
  assign bus.out_data       = empty ? '0 : mem[rptr[AW-1:0]];
  assign bus.outstanding    = cnt;
  assign bus.overflow_err   = ovf_q;
  assign bus.unexpected_err = unx_q;
  assign bus.timeout_err    = to_q;
endmodule

// File: tb/tb_result_collector.sv
// Directed self-checking bench for result_collector.
// Drives and samples 1 time unit after each rising edge.
module tb_result_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic exp_to;

  result_collector_if #(.WIDTH(32), .CNT_W(4)) bus ();

  result_collector #(
    .WIDTH(32), .DEPTH(4), .CNT_W(4), .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue_result(input logic [31:0] v);
    bus.input_valid = 1'b1;
    tick();
    bus.input_valid = 1'b0;
    tick();
    bus.result = v;
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rt [3];
    rt[0] = 32'd38;
    rt[1] = 32'd49;
    rt[2] = 32'd103;
`ifdef RESULT_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    bus.input_valid = 1'b0;
    bus.result = '0;
    bus.result_ready = 1'b0;
    bus.out_ack = 1'b0;
    bus.clear_err = 1'b0;

    repeat (3) tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_outst", bus.outstanding, 0);
    chk("rst_ovf", bus.overflow_err, 0);
    chk("rst_unx", bus.unexpected_err, 0);
    chk("rst_to", bus.timeout_err, 0);
    reset = 1'b0;
    tick();

    // round trip, consumer always acking
    bus.out_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.input_valid = 1'b1;
      tick();
      bus.input_valid = 1'b0;
      chk("rt_lat", bus.outstanding, 0);
      tick();
      chk("rt_outst", bus.outstanding, 1);
      bus.result = rt[i];
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
      chk("rt_valid", bus.out_valid, 1);
      chk("rt_data", bus.out_data, rt[i]);
      tick();
      tick();
      chk("rt_empty", bus.out_valid, 0);
    end
    chk("rt_outst0", bus.outstanding, 0);
    chk("rt_ovf", bus.overflow_err, 0);
    chk("rt_unx", bus.unexpected_err, 0);
    bus.out_ack = 1'b0;

    // fill and overflow
    for (int i = 0; i < 4; i++) issue_result(32'd10 + i);
    chk("fill_ovf0", bus.overflow_err, 0);
    chk("fill_hold", bus.out_data, 10);
    issue_result(32'd14);
    chk("fill_ovf1", bus.overflow_err, 1);
    chk("fill_outst", bus.outstanding, 0);
    bus.out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_valid", bus.out_valid, 1);
      chk("fill_data", bus.out_data, 32'd10 + i);
      tick();
    end
    chk("fill_empty", bus.out_valid, 0);
    bus.out_ack = 1'b0;
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    chk("fill_clr", bus.overflow_err, 0);

    // full plus simultaneous pop
    for (int i = 0; i < 4; i++) issue_result(32'd20 + i);
    bus.input_valid = 1'b1;
    tick();
    bus.input_valid = 1'b0;
    tick();
    bus.result = 32'd24;
    bus.result_ready = 1'b1;
    bus.out_ack = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    bus.out_ack = 1'b0;
    chk("fp_ovf", bus.overflow_err, 0);
    chk("fp_head", bus.out_data, 21);
    chk("fp_outst", bus.outstanding, 0);
    bus.out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fp_data", bus.out_data, 32'd21 + i);
      tick();
    end
    chk("fp_empty", bus.out_valid, 0);
    bus.out_ack = 1'b0;

    // spurious results and clear/set collision
    bus.result = 32'd55;
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    chk("sp_unx", bus.unexpected_err, 1);
    chk("sp_data", bus.out_data, 55);
    chk("sp_outst", bus.outstanding, 0);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    chk("sp_clr", bus.unexpected_err, 0);
    bus.result = 32'd56;
    bus.result_ready = 1'b1;
    bus.clear_err = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    bus.clear_err = 1'b0;
    chk("sp_setwin", bus.unexpected_err, 1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    chk("sp_clr2", bus.unexpected_err, 0);
    bus.out_ack = 1'b1;
    chk("sp_d0", bus.out_data, 55);
    tick();
    chk("sp_d1", bus.out_data, 56);
    tick();
    chk("sp_empty", bus.out_valid, 0);
    bus.out_ack = 1'b0;

    // held issue strobe counts once
    bus.input_valid = 1'b1;
    repeat (4) tick();
    bus.input_valid = 1'b0;
    tick();
    chk("hold_outst", bus.outstanding, 1);
    bus.result = 32'd77;
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    chk("hold_back", bus.outstanding, 0);
    chk("hold_unx", bus.unexpected_err, 0);
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    chk("hold_empty", bus.out_valid, 0);

    // saturation, idle wait, then reset mid-operation
    issue_result(32'd1);
    issue_result(32'd2);
    for (int i = 0; i < 16; i++) begin
      bus.input_valid = 1'b1;
      tick();
      bus.input_valid = 1'b0;
      tick();
    end
    chk("sat_outst", bus.outstanding, 15);
    chk("sat_ovf", bus.overflow_err, 1);
    chk("sat_valid", bus.out_valid, 1);
    repeat (70) tick();
    chk("to_flag", bus.timeout_err, exp_to);
    bus.input_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_data", bus.out_data, 0);
    chk("mr_outst", bus.outstanding, 0);
    chk("mr_ovf", bus.overflow_err, 0);
    chk("mr_unx", bus.unexpected_err, 0);
    chk("mr_to", bus.timeout_err, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rel_lat", bus.outstanding, 0);
    tick();
    chk("rel_issue", bus.outstanding, 1);
    tick();
    chk("rel_once", bus.outstanding, 1);
    bus.input_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
